// File: rtl/ultrasonido_multi.sv
// Multi-channel ultrasonic ranger: one scan triggers each selected sensor in
// ascending order and measures its echo width in microsecond ticks.
// Channels are measured one after another, separated by a dead time.
module ultrasonido_multi #(
    parameter int N_CH       = 4,
    parameter int W          = 16,
    parameter int DIV        = 50,
    parameter int TRIG_US    = 12,
    parameter int TIMEOUT_US = 30000,
    parameter int GAP_US     = 60
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    input  logic [N_CH-1:0]     ch_mask,
    input  logic [N_CH-1:0]     eco,
    output logic [N_CH-1:0]     trigger,
    output logic [N_CH*W-1:0]   tiempo,
    output logic [N_CH-1:0]     timeout,
    output logic                busy,
    output logic                done
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [W-1:0]  TRIG_LAST  = W'(TRIG_US - 1);
    localparam logic [W-1:0]  TO_LAST    = W'(TIMEOUT_US - 1);
    localparam logic [W-1:0]  TO_VAL     = W'(TIMEOUT_US);
    localparam logic [W-1:0]  GAP_LAST   = W'(GAP_US - 1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        GAP,
        DONE
    } state_t;

    state_t              state_q;
    logic [N_CH-1:0]     eco_s1_q, eco_s2_q;
    logic [PW-1:0]       presc_q, presc_d;
    logic                tick;
    logic [N_CH-1:0]     mask_q;
    logic [CW-1:0]       ch_q;
    logic [W-1:0]        cnt_q;
    logic [N_CH-1:0]     trigger_q;
    logic [N_CH*W-1:0]   tiempo_q;
    logic [N_CH-1:0]     timeout_q;
    logic                busy_q, done_q;

    logic [CW-1:0]       first_ch, next_ch;
    logic                first_ok, next_ok;
    logic                echo_sel;

    // Two-flop synchroniser for the asynchronous echo inputs
    always_ff @(posedge clk) begin
        // NOTE: every register update uses <= so all flops sample the old values of their peers on the same edge.
        if (reset) begin
            eco_s1_q <= '0;
            eco_s2_q <= '0;
        end else begin
            eco_s1_q <= eco;
            eco_s2_q <= eco_s1_q;
        end
    end

    // Free-running prescaler producing a one-cycle tick every DIV clocks
    assign tick    = (presc_q == PRESC_LAST);
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) presc_q <= '0;
        else       presc_q <= presc_d;
    end

    // Lowest set channel of the live mask, and next set channel above ch_q in the latched mask
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned, which would infer a latch.
        first_ch = '0;
        first_ok = 1'b0;
        next_ch  = '0;
        next_ok  = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                first_ch = CW'(i);
                first_ok = 1'b1;
            end
            if (mask_q[i] && (i > int'(ch_q))) begin
                next_ch = CW'(i);
                next_ok = 1'b1;
            end
        end
    end

    assign echo_sel = eco_s2_q[ch_q];

    // Scan sequencer with registered trigger, result and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            ch_q      <= '0;
            cnt_q     <= '0;
            trigger_q <= '0;
            tiempo_q  <= '0;
            timeout_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (tick) begin
            case (state_q)
                IDLE: begin
                    if (init) begin
                        mask_q <= ch_mask;
                        cnt_q  <= '0;
                        if (first_ok) begin
                            ch_q      <= first_ch;
                            trigger_q <= N_CH'(1) << first_ch;
                            busy_q    <= 1'b1;
                            state_q   <= TRIG;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                TRIG: begin
                    if (cnt_q == TRIG_LAST) begin
                        trigger_q <= '0;
                        cnt_q     <= '0;
                        state_q   <= WAIT_RISE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_RISE: begin
                    if (echo_sel) begin
                        cnt_q   <= '0;
                        state_q <= MEASURE;
                    end else if (cnt_q == TO_LAST) begin
                        tiempo_q[ch_q*W +: W] <= '1;
                        timeout_q[ch_q]       <= 1'b1;
                        cnt_q                 <= '0;
                        state_q               <= GAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                MEASURE: begin
                    if (!echo_sel) begin
                        tiempo_q[ch_q*W +: W] <= cnt_q;
                        timeout_q[ch_q]       <= 1'b0;
                        cnt_q                 <= '0;
                        state_q               <= GAP;
                    end else if (cnt_q == TO_LAST) begin
                        // Saturate instead of wrapping on an echo that never falls
                        tiempo_q[ch_q*W +: W] <= TO_VAL;
                        timeout_q[ch_q]       <= 1'b1;
                        cnt_q                 <= '0;
                        state_q               <= GAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q <= '0;
                        if (next_ok) begin
                            ch_q      <= next_ch;
                            trigger_q <= N_CH'(1) << next_ch;
                            state_q   <= TRIG;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (!init) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign trigger = trigger_q;
    assign tiempo  = tiempo_q;
    assign timeout = timeout_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_ultrasonido_multi.sv
// Directed bench for ultrasonido_multi: behavioural echo stimulus driven
// against the trigger pulses, with hand-computed expected results.
module tb_ultrasonido_multi;

    localparam int N_CH       = 4;
    localparam int W          = 16;
    localparam int DIV        = 4;
    localparam int TRIG_US    = 12;
    localparam int TIMEOUT_US = 1000;
    localparam int GAP_US     = 60;

    logic                clk     = 1'b0;
    logic                reset   = 1'b1;
    logic                init    = 1'b0;
    logic [N_CH-1:0]     ch_mask = '0;
    logic [N_CH-1:0]     eco     = '0;
    logic [N_CH-1:0]     trigger;
    logic [N_CH*W-1:0]   tiempo;
    logic [N_CH-1:0]     timeout;
    logic                busy;
    logic                done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    ultrasonido_multi #(
        .N_CH       (N_CH),
        .W          (W),
        .DIV        (DIV),
        .TRIG_US    (TRIG_US),
        .TIMEOUT_US (TIMEOUT_US),
        .GAP_US     (GAP_US)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .init    (init),
        .ch_mask (ch_mask),
        .eco     (eco),
        .trigger (trigger),
        .tiempo  (tiempo),
        .timeout (timeout),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] t_of(input int k);
        return tiempo[k*W +: W];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        logic ok;
        ok = (obs >= lo) && (obs <= hi);
        total++;
        assert (ok === 1'b1) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic wait_trig(input int k, input logic lvl, input int budget, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (trigger[k] === lvl) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, found, 1);
    endtask

    task automatic wait_any_trig(input int budget, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (trigger !== '0) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, found, 1);
    endtask

    task automatic wait_done(input logic lvl, input int budget, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === lvl) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, found, 1);
    endtask

    // Counts clk cycles the trigger stays high; called on a negedge where it is high
    task automatic measure_high(input int k, output int w);
        w = 0;
        for (int i = 0; i < 400; i++) begin
            if (trigger[k] !== 1'b1) break;
            w++;
            @(negedge clk);
        end
    endtask

    task automatic echo_pulse(input int k, input int delay_ticks, input int width_ticks);
        repeat (delay_ticks * DIV) @(negedge clk);
        eco[k] = 1'b1;
        repeat (width_ticks * DIV) @(negedge clk);
        eco[k] = 1'b0;
    endtask

    initial begin
        int w;
        int fall;
        int first_done;
        logic trig_seen;
        logic busy_seen;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_trigger", trigger, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tiempo", tiempo, 0);
        check("rst_timeout", timeout, 0);
        reset = 1'b0;

        // Single channel, 100-tick echo 50 ticks after trigger
        ch_mask = 4'b0001;
        init    = 1'b1;
        wait_trig(0, 1'b1, 20, "s1_trig0_rise");
        check("s1_busy", busy, 1);
        check("s1_trig_others", trigger[3:1], 0);
        measure_high(0, w);
        check("s1_trig0_width", w, TRIG_US * DIV);
        echo_pulse(0, 50, 100);
        wait_done(1'b1, 1000, "s1_done_rise");
        check_range("s1_tiempo0", int'(t_of(0)), 99, 101);
        check("s1_timeout0", timeout[0], 0);
        check("s1_busy_low", busy, 0);
        repeat (100) @(negedge clk);
        check("s1_done_held", done, 1);
        init = 1'b0;
        wait_done(1'b0, 20, "s1_done_fall");

        // Channels 1 and 3; mask/init changes and channel-2 echo mid-scan are ignored
        ch_mask = 4'b1010;
        init    = 1'b1;
        wait_trig(1, 1'b1, 20, "s2_trig1_rise");
        ch_mask = 4'b1111;
        init    = 1'b0;
        measure_high(1, w);
        check("s2_trig1_width", w, TRIG_US * DIV);
        eco[2] = 1'b1;
        echo_pulse(1, 20, 200);
        fall = cyc;
        init = 1'b1;
        wait_any_trig(600, "s2_next_trig");
        check("s2_next_is_ch3", trigger, 4'b1000);
        check_range("s2_gap_clk", cyc - fall, GAP_US * DIV, GAP_US * DIV + 20);
        measure_high(3, w);
        eco[2] = 1'b0;
        echo_pulse(3, 10, 300);
        wait_done(1'b1, 1000, "s2_done_rise");
        check_range("s2_tiempo1", int'(t_of(1)), 199, 201);
        check_range("s2_tiempo3", int'(t_of(3)), 299, 301);
        check("s2_tiempo2_kept", t_of(2), 0);
        check_range("s2_tiempo0_kept", int'(t_of(0)), 99, 101);
        check("s2_timeout", timeout, 0);
        init = 1'b0;
        wait_done(1'b0, 20, "s2_done_fall");

        // Channel 2 with no echo: wait timeout
        ch_mask = 4'b0100;
        init    = 1'b1;
        wait_trig(2, 1'b1, 20, "s3_trig2_rise");
        measure_high(2, w);
        fall = cyc;
        wait_done(1'b1, 4600, "s3_done_rise");
        check_range("s3_wait_clk", cyc - fall, (TIMEOUT_US + GAP_US) * DIV - 10,
                    (TIMEOUT_US + GAP_US) * DIV + 10);
        check("s3_tiempo2", t_of(2), 16'hFFFF);
        check("s3_timeout", timeout, 4'b0100);
        check_range("s3_tiempo1_kept", int'(t_of(1)), 199, 201);
        init = 1'b0;
        wait_done(1'b0, 20, "s3_done_fall");

        // Channel 0 echo stuck high: saturates, scan moves on to channel 1
        ch_mask = 4'b0011;
        init    = 1'b1;
        wait_trig(0, 1'b1, 20, "s4_trig0_rise");
        measure_high(0, w);
        repeat (5 * DIV) @(negedge clk);
        eco[0] = 1'b1;
        wait_trig(1, 1'b1, 4600, "s4_trig1_rise");
        check("s4_tiempo0", t_of(0), TIMEOUT_US);
        check("s4_timeout0", timeout[0], 1);
        check("s4_busy", busy, 1);
        measure_high(1, w);
        echo_pulse(1, 5, 30);
        wait_done(1'b1, 1000, "s4_done_rise");
        check_range("s4_tiempo1", int'(t_of(1)), 29, 31);
        check("s4_timeout", timeout, 4'b0101);
        repeat (400 * DIV) @(negedge clk);
        eco[0] = 1'b0;
        init   = 1'b0;
        wait_done(1'b0, 20, "s4_done_fall");

        // Reset in MEASURE, then a normal scan
        ch_mask = 4'b0001;
        init    = 1'b1;
        wait_trig(0, 1'b1, 20, "s5_trig0_rise");
        measure_high(0, w);
        repeat (5 * DIV) @(negedge clk);
        eco[0] = 1'b1;
        repeat (20 * DIV) @(negedge clk);
        check("s5_busy_pre", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("s5_rst_trigger", trigger, 0);
        check("s5_rst_busy", busy, 0);
        check("s5_rst_done", done, 0);
        check("s5_rst_tiempo", tiempo, 0);
        check("s5_rst_timeout", timeout, 0);
        eco[0] = 1'b0;
        init   = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        init  = 1'b1;
        wait_trig(0, 1'b1, 20, "s5_retrig0_rise");
        measure_high(0, w);
        echo_pulse(0, 10, 40);
        wait_done(1'b1, 1000, "s5_done_rise");
        check_range("s5_tiempo0", int'(t_of(0)), 39, 41);
        check("s5_timeout0", timeout[0], 0);
        init = 1'b0;
        wait_done(1'b0, 20, "s5_done_fall");

        // Reset during TRIG drops the trigger on the next edge
        ch_mask = 4'b0010;
        init    = 1'b1;
        wait_trig(1, 1'b1, 20, "s5b_trig1_rise");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("s5b_trig_drop", trigger, 0);
        check("s5b_busy", busy, 0);
        init = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Empty mask: done quickly, no trigger, never busy
        ch_mask    = 4'b0000;
        init       = 1'b1;
        trig_seen  = 1'b0;
        busy_seen  = 1'b0;
        first_done = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (trigger !== '0) trig_seen = 1'b1;
            if (busy !== 1'b0) busy_seen = 1'b1;
            if (done === 1'b1 && first_done < 0) first_done = i;
        end
        check_range("s6_done_latency", first_done, 0, 2 * DIV);
        check("s6_no_trigger", trig_seen, 0);
        check("s6_no_busy", busy_seen, 0);
        check("s6_done_held", done, 1);
        init = 1'b0;
        wait_done(1'b0, 20, "s6_done_fall");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
